// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: inter-stage pipeline register with a valid/ready handshake,
// a one-entry skid buffer and a synchronous flush. Register-select fields are
// sliced from the payload when an entry is captured and travel with it.
//
// Ports:
//   CLK, nRST            rising-edge clock, asynchronous active-low reset
//   flush                squash held and incoming entries (highest priority)
//   in_valid/in_ready    upstream handshake; in_ready is a flop (~skid_v)
//   in_data, in_aux      upstream payload and sideband
//   out_valid/out_ready  downstream handshake; out_valid is main_v
//   out_data, out_aux    payload and sideband of the main entry
//   out_rsel1/out_rsel2  select fields captured with the main entry
//   occupancy            number of entries held (0..2)
module pipe_skid_reg #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned AUX_W          = 32,
    parameter int unsigned RSEL_W         = 5,
    parameter int unsigned RS1_LSB        = 21,
    parameter int unsigned RS2_LSB        = 16,
    parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AUX_W-1:0]  in_aux,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [AUX_W-1:0]  out_aux,
    output logic [RSEL_W-1:0] out_rsel1,
    output logic [RSEL_W-1:0] out_rsel2,
    output logic [1:0]        occupancy
);

    // Reject select fields that do not fit inside the payload.
    if (RS1_LSB + RSEL_W > DATA_W) begin : g_rs1_range_err
        $error("pipe_skid_reg: RS1_LSB + RSEL_W exceeds DATA_W");
    end
    if (RS2_LSB + RSEL_W > DATA_W) begin : g_rs2_range_err
        $error("pipe_skid_reg: RS2_LSB + RSEL_W exceeds DATA_W");
    end

    logic              main_v_q, main_v_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [AUX_W-1:0]  main_aux_q, main_aux_d;
    logic [RSEL_W-1:0] main_rs1_q, main_rs1_d;
    logic [RSEL_W-1:0] main_rs2_q, main_rs2_d;

    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [AUX_W-1:0]  skid_aux_q, skid_aux_d;
    logic [RSEL_W-1:0] skid_rs1_q, skid_rs1_d;
    logic [RSEL_W-1:0] skid_rs2_q, skid_rs2_d;

    logic accept;
    logic main_free;
    logic [RSEL_W-1:0] in_rs1;
    logic [RSEL_W-1:0] in_rs2;

    assign in_rs1 = in_data[RS1_LSB +: RSEL_W];
    assign in_rs2 = in_data[RS2_LSB +: RSEL_W];

    always_comb begin
        // in_ready is ~skid_v, so an accept can never land on a full skid.
        accept    = in_valid & ~skid_v_q;
        main_free = ~main_v_q | out_ready;

        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        main_aux_d  = main_aux_q;
        main_rs1_d  = main_rs1_q;
        main_rs2_d  = main_rs2_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_aux_d  = skid_aux_q;
        skid_rs1_d  = skid_rs1_q;
        skid_rs2_d  = skid_rs2_q;

        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            if (CLEAR_ON_FLUSH) begin
                // Leave a NOP bubble behind rather than stale fields.
                main_data_d = '0;
                main_aux_d  = '0;
                main_rs1_d  = '0;
                main_rs2_d  = '0;
                skid_data_d = '0;
                skid_aux_d  = '0;
                skid_rs1_d  = '0;
                skid_rs2_d  = '0;
            end
        end else if (main_free) begin
            if (skid_v_q) begin
                // Skid is older than anything upstream: promote it first.
                main_v_d    = 1'b1;
                main_data_d = skid_data_q;
                main_aux_d  = skid_aux_q;
                main_rs1_d  = skid_rs1_q;
                main_rs2_d  = skid_rs2_q;
                skid_v_d    = 1'b0;
            end else begin
                main_v_d = accept;
                if (accept) begin
                    main_data_d = in_data;
                    main_aux_d  = in_aux;
                    main_rs1_d  = in_rs1;
                    main_rs2_d  = in_rs2;
                end
            end
        end else if (accept) begin
            skid_v_d    = 1'b1;
            skid_data_d = in_data;
            skid_aux_d  = in_aux;
            skid_rs1_d  = in_rs1;
            skid_rs2_d  = in_rs2;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            main_v_q    <= 1'b0;
            main_data_q <= '0;
            main_aux_q  <= '0;
            main_rs1_q  <= '0;
            main_rs2_q  <= '0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_aux_q  <= '0;
            skid_rs1_q  <= '0;
            skid_rs2_q  <= '0;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            main_aux_q  <= main_aux_d;
            main_rs1_q  <= main_rs1_d;
            main_rs2_q  <= main_rs2_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_aux_q  <= skid_aux_d;
            skid_rs1_q  <= skid_rs1_d;
            skid_rs2_q  <= skid_rs2_d;
        end
    end

    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign out_aux   = main_aux_q;
    assign out_rsel1 = main_rs1_q;
    assign out_rsel2 = main_rs2_q;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: a queue model (at most two entries,
// FIFO order) is checked every cycle against a CLEAR_ON_FLUSH=1 and a
// CLEAR_ON_FLUSH=0 instance sharing stimulus, plus a narrow 16-bit instance.
module tb_pipe_skid_reg;

    localparam int unsigned RS1 = 21;
    localparam int unsigned RS2 = 16;

    typedef struct {
        logic [31:0] d;
        logic [31:0] a;
    } entry_t;

    logic        CLK;
    logic        nRST;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic [31:0] in_aux;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data, a_out_aux;
    logic [4:0]  a_rsel1, a_rsel2;
    logic [1:0]  a_occ;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data, b_out_aux;
    logic [4:0]  b_rsel1, b_rsel2;
    logic [1:0]  b_occ;

    logic        c_flush, c_in_valid, c_out_ready;
    logic [15:0] c_in_data;
    logic [7:0]  c_in_aux;
    logic        c_in_ready, c_out_valid;
    logic [15:0] c_out_data;
    logic [7:0]  c_out_aux;
    logic [3:0]  c_rsel1, c_rsel2;
    logic [1:0]  c_occ;

    int     n_checks;
    int     n_pass;
    bit     chk_en;
    entry_t q[$];

    pipe_skid_reg #(.CLEAR_ON_FLUSH(1'b1)) u_dut_a (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_aux(in_aux),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_aux(a_out_aux), .out_rsel1(a_rsel1), .out_rsel2(a_rsel2), .occupancy(a_occ)
    );

    pipe_skid_reg #(.CLEAR_ON_FLUSH(1'b0)) u_dut_b (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_aux(in_aux),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_aux(b_out_aux), .out_rsel1(b_rsel1), .out_rsel2(b_rsel2), .occupancy(b_occ)
    );

    pipe_skid_reg #(
        .DATA_W(16), .AUX_W(8), .RSEL_W(4), .RS1_LSB(8), .RS2_LSB(4), .CLEAR_ON_FLUSH(1'b1)
    ) u_dut_c (
        .CLK(CLK), .nRST(nRST), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_aux(c_in_aux),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_aux(c_out_aux), .out_rsel1(c_rsel1), .out_rsel2(c_rsel2), .occupancy(c_occ)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, end on negedge.
    task automatic step(input bit v, input logic [31:0] d, input logic [31:0] a,
                        input bit r, input bit f);
        bit dr;
        bit ac;
        in_valid  = v;
        in_data   = d;
        in_aux    = a;
        out_ready = r;
        flush     = f;
        @(posedge CLK);
        if (f) begin
            q.delete();
        end else begin
            dr = (q.size() > 0) && r;
            ac = v && (q.size() < 2);
            if (dr) void'(q.pop_front());
            if (ac) q.push_back('{d: d, a: a});
        end
        @(negedge CLK);
    endtask

    // Every-cycle comparison of both 32-bit instances against the queue model.
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en && nRST) begin
                chk("a_out_valid", 64'(a_out_valid), 64'(q.size() > 0));
                chk("a_in_ready", 64'(a_in_ready), 64'(q.size() < 2));
                chk("a_occupancy", 64'(a_occ), 64'(q.size()));
                chk("b_out_valid", 64'(b_out_valid), 64'(q.size() > 0));
                chk("b_in_ready", 64'(b_in_ready), 64'(q.size() < 2));
                chk("b_occupancy", 64'(b_occ), 64'(q.size()));
                if (q.size() > 0) begin
                    chk("a_out_data", 64'(a_out_data), 64'(q[0].d));
                    chk("a_out_aux", 64'(a_out_aux), 64'(q[0].a));
                    chk("a_out_rsel1", 64'(a_rsel1), 64'(q[0].d[RS1 +: 5]));
                    chk("a_out_rsel2", 64'(a_rsel2), 64'(q[0].d[RS2 +: 5]));
                    chk("b_out_data", 64'(b_out_data), 64'(q[0].d));
                    chk("b_out_aux", 64'(b_out_aux), 64'(q[0].a));
                    chk("b_out_rsel1", 64'(b_rsel1), 64'(q[0].d[RS1 +: 5]));
                end
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        chk_en      = 1'b0;
        nRST        = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_aux      = '0;
        out_ready   = 1'b0;
        c_flush     = 1'b0;
        c_in_valid  = 1'b0;
        c_in_data   = '0;
        c_in_aux    = '0;
        c_out_ready = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset state.
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_occupancy", 64'(a_occ), 64'd0);
        chk("rst_out_data", 64'(a_out_data), 64'd0);
        nRST   = 1'b1;
        chk_en = 1'b1;

        // First entry after reset, plus the narrow instance.
        c_in_valid = 1'b1;
        c_in_data  = 16'h0A50;
        c_in_aux   = 8'h3C;
        step(1'b1, 32'h8C22_0004, 32'h0000_1000, 1'b0, 1'b0);
        c_in_valid = 1'b0;
        chk("first_out_valid", 64'(a_out_valid), 64'd1);
        chk("first_rsel1", 64'(a_rsel1), 64'd1);
        chk("first_rsel2", 64'(a_rsel2), 64'd2);
        chk("c_out_valid", 64'(c_out_valid), 64'd1);
        chk("c_rsel1", 64'(c_rsel1), 64'hA);
        chk("c_rsel2", 64'(c_rsel2), 64'h5);
        chk("c_out_data", 64'(c_out_data), 64'h0A50);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Streaming: one word per cycle, one cycle of latency.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 32'(i), 32'(i * 4), 1'b1, 1'b0);
            chk("stream_data", 64'(a_out_data), 64'(i));
            chk("stream_occ", 64'(a_occ), 64'd1);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Back-pressure after word 3, then release.
        for (int i = 1; i <= 3; i++) step(1'b1, 32'(i), 32'(i), 1'b1, 1'b0);
        step(1'b1, 32'd4, 32'd4, 1'b0, 1'b0);
        chk("bp_data", 64'(a_out_data), 64'd3);
        chk("bp_occ", 64'(a_occ), 64'd2);
        chk("bp_in_ready", 64'(a_in_ready), 64'd0);
        step(1'b1, 32'd5, 32'd5, 1'b0, 1'b0);
        chk("bp_hold_data", 64'(a_out_data), 64'd3);
        step(1'b1, 32'd5, 32'd5, 1'b1, 1'b0);
        chk("refill_data", 64'(a_out_data), 64'd4);
        chk("refill_occ", 64'(a_occ), 64'd1);
        chk("refill_in_ready", 64'(a_in_ready), 64'd1);
        step(1'b1, 32'd5, 32'd5, 1'b1, 1'b0);
        chk("refill_next", 64'(a_out_data), 64'd5);
        step(1'b1, 32'd6, 32'd6, 1'b0, 1'b0);
        chk("full_occ", 64'(a_occ), 64'd2);

        // Flush when full with an entry offered.
        step(1'b1, 32'hAA, 32'hAA, 1'b0, 1'b1);
        chk("flush_valid", 64'(a_out_valid), 64'd0);
        chk("flush_data_clr", 64'(a_out_data), 64'd0);
        chk("flush_aux_clr", 64'(a_out_aux), 64'd0);
        chk("flush_occ", 64'(a_occ), 64'd0);
        chk("flush_in_ready", 64'(a_in_ready), 64'd1);
        chk("flush_b_valid", 64'(b_out_valid), 64'd0);
        chk("flush_b_data_kept", 64'(b_out_data), 64'd5);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("flush_no_aa", 64'(a_out_valid), 64'd0);

        // Asynchronous reset while full.
        step(1'b1, 32'h7777_0007, 32'd7, 1'b0, 1'b0);
        step(1'b1, 32'h8888_0008, 32'd8, 1'b0, 1'b0);
        chk("pre_rst_occ", 64'(a_occ), 64'd2);
        #2;
        nRST = 1'b0;
        q.delete();
        #1;
        chk("arst_out_valid", 64'(a_out_valid), 64'd0);
        chk("arst_in_ready", 64'(a_in_ready), 64'd1);
        chk("arst_occ", 64'(a_occ), 64'd0);
        chk("arst_data", 64'(a_out_data), 64'd0);
        chk("arst_aux", 64'(a_out_aux), 64'd0);
        chk("arst_rsel1", 64'(a_rsel1), 64'd0);
        chk("arst_b_data", 64'(b_out_data), 64'd0);
        in_valid = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, $urandom, $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
